// File: rtl/it_state_ctrl.sv
// it_state_ctrl: Thumb-2 ITSTATE register with IT load, per-instruction advance and flush.
// Define IT_STATE_RESTORE_EN to add EPSR save/restore ports (epsr_it_in/epsr_it_load/epsr_it_out).
module it_state_ctrl #(
   parameter int         NESTED_ERR  = 1,
   parameter logic [7:0] RST_ITSTATE = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       it_flag,
   input  logic [7:0] it_status,
   input  logic       inst_adv,
   input  logic       flush,
`ifdef IT_STATE_RESTORE_EN
   input  logic [7:0] epsr_it_in,
   input  logic       epsr_it_load,
   output logic [7:0] epsr_it_out,
`endif
   output logic [3:0] it_cond,
   output logic       in_it_blk,
   output logic [2:0] it_remain,
   output logic       it_last,
   output logic       it_err
);
   typedef enum logic {IDLE, ACTIVE} blk_t;
   logic [7:0] itstate, st_nxt, ep_val;
   logic       err_nxt, ep_ld, is_it, load, illegal, adv, nested;
   blk_t       blk_st;
`ifdef IT_STATE_RESTORE_EN
   assign ep_ld       = epsr_it_load;
   assign ep_val      = epsr_it_in;
   assign epsr_it_out = itstate;
`else
   assign ep_ld  = 1'b0;
   assign ep_val = 8'h00;
`endif
   assign blk_st    = |itstate[3:0] ? ACTIVE : IDLE;
   assign in_it_blk = blk_st == ACTIVE;
   assign it_cond   = itstate[7:4];
   assign it_remain = itstate[0] ? 3'd4 : itstate[1] ? 3'd3 : itstate[2] ? 3'd2 : itstate[3] ? 3'd1 : 3'd0;
   assign it_last   = it_remain == 3'd1;
   // a zero mask marks a hint instruction sharing the IT opcode space
   assign is_it   = inst_adv & it_flag & |it_status[3:0];
   assign load    = is_it & blk_st == IDLE;
   assign nested  = is_it & blk_st == ACTIVE;
   assign adv     = inst_adv & blk_st == ACTIVE;
   assign illegal = it_status[7:4] == 4'hF || (it_status[7:4] == 4'hE && it_status[3:0] != 4'b1000);
   always_comb begin
      st_nxt  = itstate;
      err_nxt = 1'b0;
      if (flush)
         st_nxt = 8'h00;
      else if (ep_ld)
         st_nxt = ep_val;
      else if (load) begin
         st_nxt  = illegal ? itstate : it_status;
         err_nxt = illegal;
      end else if (adv) begin
         st_nxt  = itstate[2:0] == 3'b000 ? 8'h00 : {itstate[7:5], itstate[3:0], 1'b0};
         err_nxt = nested & (NESTED_ERR != 0);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         itstate <= RST_ITSTATE;
         it_err  <= 1'b0;
      end else begin
         itstate <= st_nxt;
         it_err  <= err_nxt;
      end
   end
endmodule

// File: doc/it_state_ctrl.md
Name: it_state_ctrl

Overview:
- Holds the architectural ITSTATE for the Thumb-2 front end.
- Consumes the IT-instruction indication (it_flag, it_status) from the pre-decoder.
- Feeds back the current condition (it_cond) and the in-block flag (in_it_blk) that the pre-decoder uses to squash failed conditional instructions.
- Advances once per instruction accepted into decode; clears on pipeline flush.

Parameters:
- NESTED_ERR, 1, when 1 an IT instruction seen inside an active IT block raises it_err; when 0 it is silently treated as an ordinary block member.
- RST_ITSTATE, 8'h00, ITSTATE value loaded on reset.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- it_flag  input  1  pre-decoder: current instruction is IT (combinational, same cycle)
- it_status  input  8  pre-decoder: {firstcond[3:0], mask[3:0]} of the IT instruction
- inst_adv  input  1  the instruction currently in pre-decode is accepted by decode this cycle (already excludes stall)
- flush  input  1  branch/exception flush; discard block
- it_cond  output  4  ITSTATE[7:4]; condition of the current instruction
- in_it_blk  output  1  ITSTATE[3:0] != 0
- it_remain  output  3  instructions left in block including current (0..4)
- it_last  output  1  it_remain == 1
- it_err  output  1  registered one-cycle pulse: unpredictable IT encoding or nested IT

Behaviour:
- State: 8-bit ITSTATE register; reset to RST_ITSTATE asynchronously on rst_n low. Derived FSM view: IDLE (ITSTATE[3:0]==0), ACTIVE (otherwise).
- All outputs are combinational from ITSTATE except it_err, which is a flop reset to 0. At reset with default: it_cond=0, in_it_blk=0, it_remain=0, it_last=0, it_err=0.
- it_remain from the lowest set bit of ITSTATE[3:0]: bit0→4, bit1→3, bit2→2, bit3→1, none→0.
- Priority per rising edge: flush > load > advance > hold.
- flush=1: ITSTATE←0 next cycle regardless of other inputs; it_err←0.
- Load: requires inst_adv & it_flag & ~in_it_blk & it_status[3:0]!=0.
  - Legal encoding: ITSTATE←it_status. The next instruction sees it_cond=firstcond, in_it_blk=1.
  - Illegal encoding, i.e. firstcond==4'hF, or firstcond==4'hE with mask!=4'b1000: ITSTATE stays 0 and it_err←1 for one cycle.
- it_flag with it_status[3:0]==0 is a hint, not IT: no load, no error.
- Nested IT (inst_adv & it_flag & in_it_blk): treated as an advance, with no load. it_err←NESTED_ERR.
- Advance: inst_adv & in_it_blk & not load.
  - If ITSTATE[2:0]==0: ITSTATE←0 (block ends).
  - Else: ITSTATE[4:0]←{ITSTATE[3:0],1'b0}, and ITSTATE[7:5] holds.
- inst_adv=0: hold. Stalls therefore freeze the block with no bound on duration.
- Latency: one cycle from the accepted IT instruction to the new ITSTATE being visible. A back-to-back instruction in the next cycle sees the loaded condition.
- Mid-operation reset: ITSTATE is forced to RST_ITSTATE immediately; no partial state is retained.

Optional Feature:
- Macro IT_STATE_RESTORE_EN enables exception save/restore of ITSTATE through the EPSR.
- With the macro defined, three ports are added:
  - epsr_it_in: input, 8 bits.
  - epsr_it_load: input, 1 bit.
  - epsr_it_out: output, 8 bits, equal to the current ITSTATE.
- epsr_it_load=1: ITSTATE←epsr_it_in next cycle, with priority below flush and above load/advance. No legality check is applied and it_err is not asserted.
- Without the macro: the ports are absent and ITSTATE changes only by reset, flush, load or advance.

Test Plan:
- ITTE EQ sequence: it_flag=1, it_status=8'h06, inst_adv=1, then three inst_adv pulses → it_cond/it_remain go 0/3, 0/2, 1/1 (it_last=1), then in_it_blk=0 and ITSTATE=0.
- Stall inside block: load 8'h18 (IT NE), hold inst_adv=0 for 5 cycles → it_cond=1, it_remain=1 stable throughout; one inst_adv → in_it_blk=0.
- Flush priority: ITSTATE=8'h0C, flush=1 together with inst_adv=1 and it_flag=1 → next cycle ITSTATE=0, it_err=0.
- Illegal encodings: it_status=8'hF8 → no load, it_err pulses for 1 cycle. it_status=8'hE4 → same. it_status=8'hE8 → loads, it_cond=4'hE.
- Nested IT with NESTED_ERR=1: ITSTATE=8'h04, it_flag=1, it_status=8'h18, inst_adv=1 → ITSTATE=8'h08 and it_err=1 for one cycle.
- Async reset mid-block: ITSTATE=8'h0C, drop rst_n between edges → outputs go to 0 immediately. With IT_STATE_RESTORE_EN: epsr_it_load=1, epsr_it_in=8'h0C → it_remain=2 next cycle.
